uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receiver with a buffered ready/valid output. It deserialises 8N1 frames (8-E/O-1 when parity is compiled in) from an asynchronous serial line and pushes completed bytes into a small FIFO. Downstream logic drains the FIFO through a ready/valid handshake. It is the receive end facing UART_TX in the link-level design, and it reports framing and overflow errors.

Parameters:
CLKS_PER_BIT, 217, clocks per bit period (25 MHz / 115200 baud); minimum 4.
FIFO_DEPTH, 4, FIFO entries; power of 2, at least 2.
FIFO_AW, 2, log2(FIFO_DEPTH).
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_PARITY_EN.

Ports:
i_Clock  in  1  system clock; one clock domain.
i_Reset  in  1  synchronous, active-high reset.
i_RX_Serial  in  1  asynchronous serial line; idles high.
o_RX_Byte  out  8  FIFO head byte (show-ahead).
o_RX_Valid  out  1  FIFO non-empty.
i_RX_Ready  in  1  consumer accepts the head byte.
o_RX_Busy  out  1  high whenever the FSM is not in IDLE.
o_Frame_Err  out  1  1-cycle pulse: stop bit sampled low.
o_Parity_Err  out  1  1-cycle pulse: parity mismatch.
o_Overflow  out  1  1-cycle pulse: byte dropped because the FIFO was full.

Behaviour:
- Input sync: 2-flop synchroniser on i_RX_Serial; both flops reset to 1. All FSM decisions use the synchronised value.
- Reset: FSM to IDLE; counters 0; FIFO emptied; partial byte discarded. All outputs 0. Reset applies even mid-frame.
- Bit counter: counts 0..CLKS_PER_BIT-1. Sample point = count reaching CLKS_PER_BIT-1. Midpoint = count reaching (CLKS_PER_BIT-1)/2 (integer division).
- FSM states and transitions:
  - IDLE: synchronised line low -> START, counter cleared.
  - START: at midpoint, line still low -> DATA, counter cleared. Line high at midpoint -> IDLE (false start; no error).
  - DATA: each sample point captures one bit, LSB first, into the shift register. After bit 7 -> PARITY if enabled, else STOP.
  - PARITY: at sample point, compare against the computed parity and record any mismatch -> STOP.
  - STOP, stop bit = 1 at sample point:
    - With a parity mismatch: pulse o_Parity_Err; no push.
    - Otherwise: push the byte.
    - Either way -> IDLE.
  - STOP, stop bit = 0 at sample point: pulse o_Frame_Err; no push -> BREAK_WAIT.
  - BREAK_WAIT: stay until the synchronised line is high -> IDLE. A held-low line must not be taken as a new start.
- Latency: a pushed byte shows on o_RX_Byte/o_RX_Valid the cycle after the stop sample. The stop sample falls about 9.5 bit periods plus 2 sync cycles after the falling start edge (10.5 periods with parity).
- FIFO:
  - Pop on o_RX_Valid && i_RX_Ready; o_RX_Byte advances the next cycle.
  - Push while full without a simultaneous pop: byte dropped and o_Overflow pulses. FIFO contents are unchanged.
  - Push while full with a simultaneous pop: both happen; no overflow.
  - Push and pop on an empty FIFO: the byte is stored first, so no same-cycle bypass.
  - Pointers use FIFO_AW+1 bits, wrap naturally, and distinguish full from empty by the MSB.
- i_RX_Ready is ignored while o_RX_Valid is 0.
- Error pulses are mutually exclusive. Each lasts exactly one cycle.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state follows DATA. The expected parity bit is the XOR of the data bits, XORed with PARITY_ODD. A mismatch discards the byte and pulses o_Parity_Err in the STOP cycle. Frame length is 11 bits.
- Undefined: no PARITY state; 10-bit frame; o_Parity_Err is tied to 0. The port list is the same in both builds.

Test Plan:
1. CLKS_PER_BIT=217, 40 ns clock. Drive frame 0x3F with i_RX_Ready=1 -> o_RX_Valid high 1 cycle with o_RX_Byte=0x3F, about 9.5*8680 ns after the start edge; no error pulses.
2. i_RX_Ready=0. Send 0x01, 0x02, 0x03, 0x04, 0x05 -> o_Overflow pulses once on 0x05. Then hold i_RX_Ready=1 -> bytes 0x01..0x04 in order, then o_RX_Valid=0.
3. Send 0xA5 with stop bit 0, line held low 3 more bit periods -> o_Frame_Err pulses once; nothing pushed; o_RX_Busy stays 1 until the line returns high; a following 0x3C is received correctly.
4. Line low for 50 clocks, then high -> no valid, no error; o_RX_Busy falls by midpoint+1 cycles.
5. Assert i_Reset for 1 cycle during data bit 4 of 0x77 -> next cycle o_RX_Busy=0 and o_RX_Valid=0. The next frame 0x5A is received exactly once and correctly.
6. UART_PARITY_EN, PARITY_ODD=0:
   - 0x37 with parity bit 0 -> o_Parity_Err pulse; no push.
   - 0x37 with parity bit 1 -> byte 0x37 delivered.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8-E/O-1 when UART_PARITY_EN is defined) feeding a small
// show-ahead FIFO drained by a ready/valid handshake; reports framing, parity and overflow errors.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Valid,
  input  logic       i_RX_Ready,
  output logic       o_RX_Busy,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err,
  output logic       o_Overflow
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam int            PW     = FIFO_AW + 1;
  localparam logic [CW-1:0] SAMPLE = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam bit            ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t        state, next_state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] clk_count;
  logic [2:0]    bit_index;
  logic [7:0]    shift_reg;
  logic          parity_bad;
  logic          at_mid, at_sample;
  logic          count_clear, capture_bit, capture_par;
  logic          push_req, frame_err_set, parity_err_set;
  logic          frame_err_q, parity_err_q, overflow_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok, overflow_set;

  assign at_mid    = (clk_count == MID);
  assign at_sample = (clk_count == SAMPLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (!rx_sync) next_state = S_START;
      S_START:      if (at_mid) next_state = rx_sync ? S_IDLE : S_DATA;
      S_DATA:       if (at_sample && bit_index == 3'd7) next_state = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY:     if (at_sample) next_state = S_STOP;
      S_STOP:       if (at_sample) next_state = rx_sync ? S_IDLE : S_BREAK_WAIT;
      S_BREAK_WAIT: if (rx_sync) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Counter runs only while timing a bit; IDLE and BREAK_WAIT hold it at zero.
  always_comb begin
    count_clear    = 1'b1;
    capture_bit    = 1'b0;
    capture_par    = 1'b0;
    push_req       = 1'b0;
    frame_err_set  = 1'b0;
    parity_err_set = 1'b0;
    case (state)
      S_START:  count_clear = at_mid;
      S_DATA: begin
        count_clear = at_sample;
        capture_bit = at_sample;
      end
      S_PARITY: begin
        count_clear = at_sample;
        capture_par = at_sample;
      end
      S_STOP: begin
        count_clear = at_sample;
        if (at_sample) begin
          if (!rx_sync)        frame_err_set  = 1'b1;
          else if (parity_bad) parity_err_set = 1'b1;
          else                 push_req       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      clk_count  <= '0;
      bit_index  <= '0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
    end else begin
      clk_count <= count_clear ? '0 : clk_count + CW'(1);
      if (state == S_START) begin
        bit_index  <= '0;
        parity_bad <= 1'b0;
      end
      if (capture_bit) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
        bit_index <= bit_index + 3'd1;
      end
      if (capture_par) parity_bad <= (rx_sync != (^shift_reg ^ ODD));
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop          = !empty && i_RX_Ready;
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      frame_err_q  <= frame_err_set;
      parity_err_q <= parity_err_set;
      overflow_q   <= overflow_set;
    end
  end

  assign o_RX_Valid   = !empty;
  assign o_RX_Byte    = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
  assign o_RX_Busy    = (state != S_IDLE);
  assign o_Frame_Err  = frame_err_q;
  assign o_Parity_Err = PAR_EN ? parity_err_q : 1'b0;
  assign o_Overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives serial frames bit by bit and checks
// delivered bytes, error pulses and busy/valid behaviour with immediate assertions.
module tb_uart_rx_fifo;

  localparam int CPB = 217;
`ifdef UART_PARITY_EN
  localparam bit TB_PAR  = 1'b1;
  localparam int LATENCY = 2282;
`else
  localparam bit TB_PAR  = 1'b0;
  localparam int LATENCY = 2065;
`endif

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic       i_RX_Serial;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Valid;
  logic       i_RX_Ready;
  logic       o_RX_Busy;
  logic       o_Frame_Err;
  logic       o_Parity_Err;
  logic       o_Overflow;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4),
    .FIFO_AW(2),
    .PARITY_ODD(0)
  ) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_Byte(o_RX_Byte),
    .o_RX_Valid(o_RX_Valid),
    .i_RX_Ready(i_RX_Ready),
    .o_RX_Busy(o_RX_Busy),
    .o_Frame_Err(o_Frame_Err),
    .o_Parity_Err(o_Parity_Err),
    .o_Overflow(o_Overflow)
  );

  always #20 i_Clock = ~i_Clock;

  int         compared   = 0;
  int         mismatched = 0;
  int         cycle      = 0;
  logic [7:0] recvQ[$];
  int         validCycles, frameErrs, parityErrs, overflows, multiErrs, riseCycle;
  logic       prevValid = 1'b0;
  int         startCyc;

  always @(posedge i_Clock) cycle <= cycle + 1;

  // Observes the DUT a few time units after each falling edge, when inputs and outputs are settled.
  always @(negedge i_Clock) begin
    #5;
    if (o_RX_Valid && i_RX_Ready) recvQ.push_back(o_RX_Byte);
    if (o_RX_Valid) validCycles++;
    if (o_RX_Valid && !prevValid) riseCycle = cycle;
    prevValid = o_RX_Valid;
    if (o_Frame_Err)  frameErrs++;
    if (o_Parity_Err) parityErrs++;
    if (o_Overflow)   overflows++;
    if ((int'(o_Frame_Err) + int'(o_Parity_Err) + int'(o_Overflow)) > 1) multiErrs++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    recvQ.delete();
    validCycles = 0;
    frameErrs   = 0;
    parityErrs  = 0;
    overflows   = 0;
    multiErrs   = 0;
    riseCycle   = 0;
  endtask

  task automatic idleBits(input int n);
    i_RX_Serial = 1'b1;
    repeat (n * CPB) @(negedge i_Clock);
  endtask

  // Sends one frame; parity (when compiled in) is even parity of data XOR parFlip.
  // The line is left at the stop-bit level on return.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parFlip);
    @(negedge i_Clock);
    i_RX_Serial = 1'b0;
    startCyc    = cycle;
    repeat (CPB) @(negedge i_Clock);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = data[i];
      repeat (CPB) @(negedge i_Clock);
    end
    if (TB_PAR) begin
      i_RX_Serial = (^data) ^ parFlip;
      repeat (CPB) @(negedge i_Clock);
    end
    i_RX_Serial = stopBit;
    repeat (CPB) @(negedge i_Clock);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    logic [7:0] bits77;
    bits77      = 8'h77;
    i_Reset     = 1'b1;
    i_RX_Serial = 1'b1;
    i_RX_Ready  = 1'b0;
    clearCounts();
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    #10;
    checkOutput("rst_busy", o_RX_Busy, 0);
    checkOutput("rst_valid", o_RX_Valid, 0);
    checkOutput("rst_byte", o_RX_Byte, 0);
    checkOutput("rst_frame", o_Frame_Err, 0);
    checkOutput("rst_parity", o_Parity_Err, 0);
    checkOutput("rst_overflow", o_Overflow, 0);

    $display("[TB] single byte 0x3F");
    i_RX_Ready = 1'b1;
    clearCounts();
    applyStimulus(8'h3F, 1'b1, 1'b0);
    idleBits(1);
    #10;
    checkOutput("t1_count", recvQ.size(), 1);
    checkOutput("t1_byte", recvQ[0], 8'h3F);
    checkOutput("t1_valid_cycles", validCycles, 1);
    checkOutput("t1_latency", riseCycle - startCyc, LATENCY);
    checkOutput("t1_errors", frameErrs + parityErrs + overflows, 0);

    $display("[TB] overflow with consumer stalled");
    @(negedge i_Clock);
    i_RX_Ready = 1'b0;
    clearCounts();
    for (int b = 1; b <= 5; b++) begin
      applyStimulus(8'(b), 1'b1, 1'b0);
      idleBits(1);
    end
    #10;
    checkOutput("t2_overflow", overflows, 1);
    checkOutput("t2_no_pop", recvQ.size(), 0);
    checkOutput("t2_valid", o_RX_Valid, 1);
    checkOutput("t2_head", o_RX_Byte, 8'h01);
    @(negedge i_Clock);
    i_RX_Ready = 1'b1;
    repeat (10) @(negedge i_Clock);
    #10;
    checkOutput("t2_drain_count", recvQ.size(), 4);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("t2_drain_%0d", b), recvQ[b], b + 1);
    checkOutput("t2_valid_after", o_RX_Valid, 0);
    checkOutput("t2_other_errs", frameErrs + parityErrs + multiErrs, 0);

    $display("[TB] framing error with held-low line");
    clearCounts();
    applyStimulus(8'hA5, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge i_Clock);
    #10;
    checkOutput("t3_frame_err", frameErrs, 1);
    checkOutput("t3_busy_held", o_RX_Busy, 1);
    checkOutput("t3_no_push", validCycles, 0);
    checkOutput("t3_other_errs", parityErrs + overflows, 0);
    @(negedge i_Clock);
    i_RX_Serial = 1'b1;
    repeat (5) @(negedge i_Clock);
    #10;
    checkOutput("t3_busy_released", o_RX_Busy, 0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    idleBits(1);
    #10;
    checkOutput("t3_next_count", recvQ.size(), 1);
    checkOutput("t3_next_byte", recvQ[0], 8'h3C);
    checkOutput("t3_frame_err_total", frameErrs, 1);

    $display("[TB] false start glitch");
    clearCounts();
    @(negedge i_Clock);
    i_RX_Serial = 1'b0;
    repeat (50) @(negedge i_Clock);
    #10;
    checkOutput("t4_busy_low", o_RX_Busy, 1);
    @(negedge i_Clock);
    i_RX_Serial = 1'b1;
    repeat (64) @(negedge i_Clock);
    #10;
    checkOutput("t4_busy_fell", o_RX_Busy, 0);
    checkOutput("t4_no_valid", validCycles, 0);
    checkOutput("t4_no_errs", frameErrs + parityErrs + overflows, 0);

    $display("[TB] reset mid-frame");
    i_RX_Ready = 1'b0;
    clearCounts();
    applyStimulus(8'h11, 1'b1, 1'b0);
    idleBits(1);
    #10;
    checkOutput("t5_pre_valid", o_RX_Valid, 1);
    @(negedge i_Clock);
    i_RX_Serial = 1'b0;
    repeat (CPB) @(negedge i_Clock);
    for (int i = 0; i < 4; i++) begin
      i_RX_Serial = bits77[i];
      repeat (CPB) @(negedge i_Clock);
    end
    i_RX_Serial = bits77[4];
    repeat (CPB / 2) @(negedge i_Clock);
    checkOutput("t5_busy_before", o_RX_Busy, 1);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    #10;
    checkOutput("t5_busy_after", o_RX_Busy, 0);
    checkOutput("t5_valid_after", o_RX_Valid, 0);
    idleBits(3);
    i_RX_Ready = 1'b1;
    clearCounts();
    applyStimulus(8'h5A, 1'b1, 1'b0);
    idleBits(1);
    #10;
    checkOutput("t5_next_count", recvQ.size(), 1);
    checkOutput("t5_next_byte", recvQ[0], 8'h5A);
    checkOutput("t5_no_errs", frameErrs + parityErrs + overflows, 0);

`ifdef UART_PARITY_EN
    $display("[TB] parity checks");
    clearCounts();
    applyStimulus(8'h37, 1'b1, 1'b1);
    idleBits(1);
    #10;
    checkOutput("t6_parity_err", parityErrs, 1);
    checkOutput("t6_bad_no_push", validCycles, 0);
    checkOutput("t6_no_frame", frameErrs, 0);
    applyStimulus(8'h37, 1'b1, 1'b0);
    idleBits(1);
    #10;
    checkOutput("t6_good_count", recvQ.size(), 1);
    checkOutput("t6_good_byte", recvQ[0], 8'h37);
    checkOutput("t6_parity_total", parityErrs, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
